// File: rtl/lstm_seq_ctrl_if.sv
// LSTM sequencer bus: control handshake, operand-memory addresses and strobes, and the
// net-phase h_new/h_word path between lstm_seq_ctrl and the MAC/activation datapath.
//   master : the sequencer (drives addresses/strobes, busy/done, h_word)
//   slave  : the controller/datapath (drives start, num_steps, h_new)
// Widths are derived from the parameters and must match the sequencer instance.
interface lstm_seq_ctrl_if #(
  parameter int unsigned WL   = 16,
  parameter int unsigned HID  = 64,
  parameter int unsigned NX   = 2,
  parameter int unsigned PACK = 16,
  parameter int unsigned TW   = 8
);
  localparam int unsigned NH   = HID / PACK;
  localparam int unsigned Rows = 4 * HID;
  localparam int unsigned RowW = $clog2(Rows);
  localparam int unsigned XW   = $clog2(NX * (2 ** TW));
  localparam int unsigned WxW  = $clog2(Rows * NX);
  localparam int unsigned HW   = (NH > 1) ? $clog2(NH) : 1;
  localparam int unsigned WhW  = $clog2(Rows * NH);
  localparam int unsigned UW   = (HID > 1) ? $clog2(HID) : 1;

  logic                 start;
  logic [TW-1:0]        num_steps;
  logic                 busy;
  logic                 done;
  logic [RowW-1:0]      b_addr;
  logic [XW-1:0]        x_addr;
  logic [WxW-1:0]       wx_addr;
  logic [HW-1:0]        h_raddr;
  logic [HW-1:0]        h_waddr;
  logic [WhW-1:0]       wh_addr;
  logic                 b_valid;
  logic                 x_valid;
  logic                 h_valid;
  logic                 row_last;
  logic                 gate_we;
  logic                 accum_rst_gate;
  logic [RowW-1:0]      gate_waddr;
  logic [RowW-1:0]      gate_raddr;
  logic [RowW-1:0]      gate_raddr2;
  logic                 f_valid;
  logic                 i_valid;
  logic                 accum_rst_net;
  logic                 c_we;
  logic [UW-1:0]        c_addr;
  logic [WL-1:0]        h_new;
  logic [PACK*WL-1:0]   h_word;
  logic                 h_we;

  modport master (
    input  start, num_steps, h_new,
    output busy, done, b_addr, x_addr, wx_addr, h_raddr, h_waddr, wh_addr,
           b_valid, x_valid, h_valid, row_last, gate_we, accum_rst_gate, gate_waddr,
           gate_raddr, gate_raddr2, f_valid, i_valid, accum_rst_net, c_we, c_addr,
           h_word, h_we
  );

  modport slave (
    output start, num_steps, h_new,
    input  busy, done, b_addr, x_addr, wx_addr, h_raddr, h_waddr, wh_addr,
           b_valid, x_valid, h_valid, row_last, gate_we, accum_rst_gate, gate_waddr,
           gate_raddr, gate_raddr2, f_valid, i_valid, accum_rst_net, c_we, c_addr,
           h_word, h_we
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// LSTM cell sequencer: address/strobe schedule for a multi-timestep layer.
//   GATE : streams bias, x/wx and h/wh operands for all 4*HID gate rows (1+NX+NH cycles/row)
//   DRAIN: GATE_PIPE cycles so the last gate write lands before the first net read
//   NET  : 6 cycles per hidden unit, reads f, i/g, o, writes c, packs h_new into h_word
// Ports: clk, rst_n (async active-low), bus (lstm_seq_ctrl_if.master).
// Optional: define SEQ_STALL_EN to add input 'stall', which freezes all state and masks
// every strobe; masked strobes issue on the first cycle after stall falls.
module lstm_seq_ctrl #(
  parameter int unsigned WL        = 16,
  parameter int unsigned HID       = 64,
  parameter int unsigned NX        = 2,
  parameter int unsigned PACK      = 16,
  parameter int unsigned GATE_PIPE = 4,
  parameter int unsigned TW        = 8
) (
  input logic             clk,
  input logic             rst_n,
`ifdef SEQ_STALL_EN
  input logic             stall,
`endif
  lstm_seq_ctrl_if.master bus
);
  localparam int unsigned NH   = HID / PACK;
  localparam int unsigned L    = 1 + NX + NH;
  localparam int unsigned Rows = 4 * HID;
  localparam int unsigned RowW = $clog2(Rows);
  localparam int unsigned CycW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned DrW  = (GATE_PIPE > 1) ? $clog2(GATE_PIPE) : 1;
  localparam int unsigned UW   = (HID > 1) ? $clog2(HID) : 1;
  localparam int unsigned XW   = $clog2(NX * (2 ** TW));
  localparam int unsigned WxW  = $clog2(Rows * NX);
  localparam int unsigned HW   = (NH > 1) ? $clog2(NH) : 1;
  localparam int unsigned WhW  = $clog2(Rows * NH);

  typedef enum logic [2:0] {StIdle, StGate, StDrain, StNet, StFin} state_e;

  state_e state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [DrW-1:0]  drn_q, drn_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [2:0]      ncyc_q, ncyc_d;
  logic [TW-1:0]   t_q, t_d, steps_q, steps_d;

  logic [GATE_PIPE-1:0]           pipe_vld_q;
  logic [GATE_PIPE-1:0][RowW-1:0] pipe_row_q;
  logic                           h_we_q;
  logic [HW-1:0]                  h_waddr_q;
  logic [PACK*WL-1:0]             h_word_q;

  // Address outputs hold their last issued value between strobes.
  logic [RowW-1:0] b_addr_q, b_addr_d, gw_addr_q, gw_addr_d;
  logic [RowW-1:0] gr_addr_q, gr_addr_d, gr2_addr_q, gr2_addr_d;
  logic [XW-1:0]   x_addr_q, x_addr_d;
  logic [WxW-1:0]  wx_addr_q, wx_addr_d;
  logic [HW-1:0]   hr_addr_q, hr_addr_d;
  logic [WhW-1:0]  wh_addr_q, wh_addr_d;
  logic [UW-1:0]   c_addr_q, c_addr_d;

  logic        run, gate_act, net_act;
  logic        b_raw, x_raw, h_raw, rl_raw, f_raw, i_raw, arn_raw, cwe_raw, hwe_set;
  logic [31:0] k_idx, j_idx, slot_idx;

`ifdef SEQ_STALL_EN
  assign run = ~stall;
`else
  assign run = 1'b1;
`endif

  assign gate_act = (state_q == StGate);
  assign net_act  = (state_q == StNet);
  assign k_idx    = 32'(cyc_q) - 32'd1;
  assign j_idx    = 32'(cyc_q) - 32'd1 - NX;
  assign slot_idx = 32'(unit_q) % PACK;

  assign b_raw   = gate_act && (cyc_q == '0);
  assign x_raw   = gate_act && (cyc_q != '0) && (32'(cyc_q) <= NX);
  assign h_raw   = gate_act && (32'(cyc_q) > NX);
  assign rl_raw  = gate_act && (cyc_q == CycW'(L - 1));
  assign f_raw   = net_act && (ncyc_q == 3'd0);
  assign i_raw   = net_act && (ncyc_q == 3'd1);
  assign arn_raw = net_act && (ncyc_q == 3'd3);
  assign cwe_raw = net_act && (ncyc_q == 3'd5);
  // Last slot of a packed word filled: write it out on the next cycle.
  assign hwe_set = cwe_raw && (slot_idx == PACK - 1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cyc_d   = cyc_q;
    drn_d   = drn_q;
    unit_d  = unit_q;
    ncyc_d  = ncyc_q;
    t_d     = t_q;
    steps_d = steps_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          steps_d = bus.num_steps;
          t_d     = '0;
          state_d = (bus.num_steps == '0) ? StFin : StGate;
        end
      end
      StGate: begin
        if (cyc_q == CycW'(L - 1)) begin
          cyc_d = '0;
          if (row_q == RowW'(Rows - 1)) begin
            row_d   = '0;
            state_d = StDrain;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StDrain: begin
        if (drn_q == DrW'(GATE_PIPE - 1)) begin
          drn_d   = '0;
          state_d = StNet;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      StNet: begin
        if (ncyc_q == 3'd5) begin
          ncyc_d = '0;
          if (unit_q == UW'(HID - 1)) begin
            unit_d = '0;
            // steps_q >= 1 here: a zero count never leaves IDLE for GATE.
            if (t_q == steps_q - 1'b1) begin
              t_d     = '0;
              state_d = StFin;
            end else begin
              t_d     = t_q + 1'b1;
              state_d = StGate;
            end
          end else begin
            unit_d = unit_q + 1'b1;
          end
        end else begin
          ncyc_d = ncyc_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    b_addr_d   = b_addr_q;
    x_addr_d   = x_addr_q;
    wx_addr_d  = wx_addr_q;
    hr_addr_d  = hr_addr_q;
    wh_addr_d  = wh_addr_q;
    gw_addr_d  = gw_addr_q;
    gr_addr_d  = gr_addr_q;
    gr2_addr_d = gr2_addr_q;
    c_addr_d   = c_addr_q;
    if (b_raw) b_addr_d = row_q;
    if (x_raw) begin
      x_addr_d  = XW'(32'(t_q) * NX + k_idx);
      wx_addr_d = WxW'(32'(row_q) * NX + k_idx);
    end
    if (h_raw) begin
      hr_addr_d = HW'(j_idx);
      wh_addr_d = WhW'(32'(row_q) * NH + j_idx);
    end
    if (pipe_vld_q[GATE_PIPE-1]) gw_addr_d = pipe_row_q[GATE_PIPE-1];
    if (f_raw) gr_addr_d = RowW'(HID + 32'(unit_q));
    if (i_raw) begin
      gr_addr_d  = RowW'(unit_q);
      gr2_addr_d = RowW'(2 * HID + 32'(unit_q));
    end
    if (cwe_raw) begin
      gr_addr_d = RowW'(3 * HID + 32'(unit_q));
      c_addr_d  = unit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      cyc_q      <= '0;
      drn_q      <= '0;
      unit_q     <= '0;
      ncyc_q     <= '0;
      t_q        <= '0;
      steps_q    <= '0;
      pipe_vld_q <= '0;
      pipe_row_q <= '0;
      h_we_q     <= 1'b0;
      h_waddr_q  <= '0;
      h_word_q   <= '0;
    end else if (run) begin
      state_q       <= state_d;
      row_q         <= row_d;
      cyc_q         <= cyc_d;
      drn_q         <= drn_d;
      unit_q        <= unit_d;
      ncyc_q        <= ncyc_d;
      t_q           <= t_d;
      steps_q       <= steps_d;
      pipe_vld_q[0] <= rl_raw;
      pipe_row_q[0] <= row_q;
      for (int i = 1; i < GATE_PIPE; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_row_q[i] <= pipe_row_q[i-1];
      end
      h_we_q <= hwe_set;
      if (hwe_set) h_waddr_q <= HW'(32'(unit_q) / PACK);
      if (cwe_raw) h_word_q[slot_idx*WL +: WL] <= bus.h_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_addr_q   <= '0;
      x_addr_q   <= '0;
      wx_addr_q  <= '0;
      hr_addr_q  <= '0;
      wh_addr_q  <= '0;
      gw_addr_q  <= '0;
      gr_addr_q  <= '0;
      gr2_addr_q <= '0;
      c_addr_q   <= '0;
    end else begin
      b_addr_q   <= b_addr_d;
      x_addr_q   <= x_addr_d;
      wx_addr_q  <= wx_addr_d;
      hr_addr_q  <= hr_addr_d;
      wh_addr_q  <= wh_addr_d;
      gw_addr_q  <= gw_addr_d;
      gr_addr_q  <= gr_addr_d;
      gr2_addr_q <= gr2_addr_d;
      c_addr_q   <= c_addr_d;
    end
  end

  assign bus.busy           = (state_q == StGate) || (state_q == StDrain) || (state_q == StNet);
  assign bus.done           = (state_q == StFin) && run;
  assign bus.b_valid        = b_raw && run;
  assign bus.x_valid        = x_raw && run;
  assign bus.h_valid        = h_raw && run;
  assign bus.row_last       = rl_raw && run;
  assign bus.gate_we        = pipe_vld_q[GATE_PIPE-1] && run;
  assign bus.accum_rst_gate = pipe_vld_q[GATE_PIPE-1] && run;
  assign bus.f_valid        = f_raw && run;
  assign bus.i_valid        = i_raw && run;
  assign bus.accum_rst_net  = arn_raw && run;
  assign bus.c_we           = cwe_raw && run;
  assign bus.h_we           = h_we_q && run;
  assign bus.b_addr         = b_addr_d;
  assign bus.x_addr         = x_addr_d;
  assign bus.wx_addr        = wx_addr_d;
  assign bus.h_raddr        = hr_addr_d;
  assign bus.wh_addr        = wh_addr_d;
  assign bus.gate_waddr     = gw_addr_d;
  assign bus.gate_raddr     = gr_addr_d;
  assign bus.gate_raddr2    = gr2_addr_d;
  assign bus.c_addr         = c_addr_d;
  assign bus.h_waddr        = h_waddr_q;
  assign bus.h_word         = h_word_q;
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl at HID=4, PACK=2, NX=1, GATE_PIPE=4. The expected schedule is
// computed per cycle from the layer arithmetic (step/row/unit offsets), not from the RTL.
module tb_lstm_seq_ctrl;
  localparam int unsigned WL = 16, HID = 4, NX = 1, PACK = 2, GATE_PIPE = 4, TW = 8;
  localparam int NH = HID / PACK;
  localparam int L  = 1 + NX + NH;
  localparam int GL = 4 * HID * L;
  localparam int SL = GL + GATE_PIPE + 6 * HID;
  localparam int SB = 0, SX = 1, SH = 2, SRL = 3, SGW = 4, SF = 5, SI = 6, SAR = 7, SCW = 8,
                 SHW = 9, SD = 10;

  typedef struct {
    logic [10:0] stb;
    bit          busy;
    int a_b, a_x, a_wx, a_hr, a_wh, a_gw, a_gr, a_gr2, a_c, a_hw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
`ifdef SEQ_STALL_EN
  logic stall;
`endif
  int checks = 0;
  int errors = 0;
  logic [WL-1:0] hval [HID];

  lstm_seq_ctrl_if #(.WL(WL), .HID(HID), .NX(NX), .PACK(PACK), .TW(TW)) bus ();

  lstm_seq_ctrl #(
    .WL(WL), .HID(HID), .NX(NX), .PACK(PACK), .GATE_PIPE(GATE_PIPE), .TW(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SEQ_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] obs_stb;
  logic [63:0] obs_addr;
  assign obs_stb = {bus.accum_rst_gate, bus.done, bus.h_we, bus.c_we, bus.accum_rst_net,
                    bus.i_valid, bus.f_valid, bus.gate_we, bus.row_last, bus.h_valid,
                    bus.x_valid, bus.b_valid};
  assign obs_addr = 64'({bus.b_addr, bus.x_addr, bus.wx_addr, bus.h_raddr, bus.h_waddr,
                         bus.wh_addr, bus.gate_waddr, bus.gate_raddr, bus.gate_raddr2,
                         bus.c_addr});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for cycle idx of an n-step run (idx 0 = first cycle after start).
  function automatic exp_t model(int idx, int n);
    exp_t e;
    int total, off, row, cyc, u, c, p, q;
    e = '{default: 0};
    total = n * SL;
    if (idx < total) begin
      e.busy = 1'b1;
      off = idx % SL;
      if (off < GL) begin
        row = off / L;
        cyc = off % L;
        if (cyc == 0) begin
          e.stb[SB] = 1'b1; e.a_b = row;
        end else if (cyc <= NX) begin
          e.stb[SX] = 1'b1; e.a_x = (idx / SL) * NX + cyc - 1; e.a_wx = row * NX + cyc - 1;
        end else begin
          e.stb[SH] = 1'b1; e.a_hr = cyc - 1 - NX; e.a_wh = row * NH + cyc - 1 - NX;
        end
        if (cyc == L - 1) e.stb[SRL] = 1'b1;
      end else if (off >= GL + GATE_PIPE) begin
        u = (off - GL - GATE_PIPE) / 6;
        c = (off - GL - GATE_PIPE) % 6;
        if (c == 0) begin e.stb[SF] = 1'b1; e.a_gr = HID + u; end
        if (c == 1) begin e.stb[SI] = 1'b1; e.a_gr = u; e.a_gr2 = 2 * HID + u; end
        if (c == 3) e.stb[SAR] = 1'b1;
        if (c == 5) begin e.stb[SCW] = 1'b1; e.a_c = u; e.a_gr = 3 * HID + u; end
      end
    end
    if (idx == total) e.stb[SD] = 1'b1;
    p = idx - GATE_PIPE;
    if (p >= 0 && p < total && (p % SL) < GL && (p % SL) % L == L - 1) begin
      e.stb[SGW] = 1'b1; e.a_gw = (p % SL) / L;
    end
    p = idx - 1;
    if (p >= 0 && p < total && (p % SL) >= GL + GATE_PIPE) begin
      q = (p % SL) - GL - GATE_PIPE;
      if (q % 6 == 5 && (q / 6) % PACK == PACK - 1) begin
        e.stb[SHW] = 1'b1; e.a_hw = (q / 6) / PACK;
      end
    end
    return e;
  endfunction

  task automatic run(input int n, input bit do_stall);
    int total, idx, stall_at, stall_left;
    bit stalled;
    exp_t e;
    logic [PACK*WL-1:0] hw;
    total = n * SL;
    idx = 0;
    stall_at = (total > 4) ? int'($urandom_range(total - 2, 1)) : -1;
    stall_left = 10;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_steps = TW'(n);
    while (idx <= total + 3) begin
      @(negedge clk);
      bus.start = (idx <= total) && ($urandom_range(7, 0) == 0);
      bus.num_steps = TW'($urandom);
      bus.h_new = WL'($urandom);
      stalled = do_stall && (idx == stall_at) && (stall_left > 0);
`ifdef SEQ_STALL_EN
      stall = stalled;
`else
      stalled = 1'b0;
`endif
      #1;
      e = model(idx, n);
      chk("busy", 64'(bus.busy), 64'(e.busy));
      if (stalled) begin
        chk("stall_strobes", 64'(obs_stb), 64'd0);
        stall_left--;
      end else begin
        chk("strobes", 64'(obs_stb), 64'({e.stb[SGW], e.stb}));
        if (e.stb[SB]) chk("b_addr", 64'(bus.b_addr), 64'(e.a_b));
        if (e.stb[SX]) begin
          chk("x_addr", 64'(bus.x_addr), 64'(e.a_x));
          chk("wx_addr", 64'(bus.wx_addr), 64'(e.a_wx));
        end
        if (e.stb[SH]) begin
          chk("h_raddr", 64'(bus.h_raddr), 64'(e.a_hr));
          chk("wh_addr", 64'(bus.wh_addr), 64'(e.a_wh));
        end
        if (e.stb[SGW]) chk("gate_waddr", 64'(bus.gate_waddr), 64'(e.a_gw));
        if (e.stb[SF] || e.stb[SI] || e.stb[SCW])
          chk("gate_raddr", 64'(bus.gate_raddr), 64'(e.a_gr));
        if (e.stb[SI]) chk("gate_raddr2", 64'(bus.gate_raddr2), 64'(e.a_gr2));
        if (e.stb[SCW]) begin
          chk("c_addr", 64'(bus.c_addr), 64'(e.a_c));
          hval[e.a_c] = bus.h_new;
        end
        if (e.stb[SHW]) begin
          for (int s = 0; s < PACK; s++) hw[s*WL +: WL] = hval[e.a_hw * PACK + s];
          chk("h_waddr", 64'(bus.h_waddr), 64'(e.a_hw));
          chk("h_word", 64'(bus.h_word), 64'(hw));
        end
        idx++;
      end
    end
    bus.start = 1'b0;
`ifdef SEQ_STALL_EN
    stall = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.h_new = '0;
`ifdef SEQ_STALL_EN
    stall = 1'b0;
`endif
    #12;
    chk("rst_strobes", 64'(obs_stb), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_addr", obs_addr, 64'd0);
    chk("rst_h_word", 64'(bus.h_word), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 1'b0);
    run(3, 1'b0);
    run(0, 1'b0);
    run(int'($urandom_range(3, 1)), 1'b1);
    run(int'($urandom_range(2, 1)), 1'b0);

    // Abort mid-GATE at row 7; everything must clear without waiting for a clock.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_steps = TW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7 * L + 1) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    chk("pre_rst_row", 64'(bus.b_addr), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", 64'(obs_stb), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_addr", obs_addr, 64'd0);
    chk("async_rst_h_word", 64'(bus.h_word), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
- Parametrised LSTM cell sequencer for the address/strobe schedule of a multi-timestep layer.
- Gate phase streams bias, x/wx and h/wh operands for all 4*HID gate rows and writes each gate result back into gate memory.
- Net phase walks hidden units: reads f, i/g, o, writes c and packs h_new into PACK-wide h words.
- Loops over num_steps timesteps without restart and sits between the operand memories and the MAC/activation datapath.

Parameters:
- WL, 16, datapath word length (h_new and each h_word slot).
- HID, 64, hidden units; gate rows = 4*HID (i: 0..HID-1, f: HID.., g: 2HID.., o: 3HID..).
- NX, 2, packed x words per timestep.
- PACK, 16, h values per packed h word; NH = HID/PACK (HID must be a multiple of PACK).
- GATE_PIPE, 4, cycles from row end to the gate result being valid on the write port.
- TW, 8, width of num_steps.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored unless IDLE.
- num_steps  in  TW  timestep count, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of the run.
- b_addr  out  clog2(4*HID)  bias address = row.
- x_addr  out  clog2(NX*2^TW)  x word address = t*NX + k.
- wx_addr  out  clog2(4*HID*NX)  = row*NX + k.
- h_raddr, h_waddr  out  clog2(NH)  h word read/write address.
- wh_addr  out  clog2(4*HID*NH)  = row*NH + j.
- b_valid, x_valid, h_valid, row_last  out  1 each  operand strobes.
- gate_we  out  1  gate result write; accum_rst_gate equals gate_we.
- accum_rst_gate  out  1  see gate_we.
- gate_waddr  out  clog2(4*HID)  row index delayed GATE_PIPE cycles.
- gate_raddr, gate_raddr2  out  clog2(4*HID)  net-phase read ports.
- f_valid, i_valid, accum_rst_net, c_we  out  1 each  net strobes.
- c_addr  out  clog2(HID)  c address = u.
- h_new  in  WL  hidden value, sampled at net cycle 5.
- h_word  out  PACK*WL  packed h write data.
- h_we  out  1  h word write strobe.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters 0, all outputs 0 including h_word. Reset mid-run aborts immediately; no done pulse.
- FSM IDLE -> GATE -> DRAIN -> NET -> (GATE if t<num_steps-1 else FIN) -> IDLE.
- IDLE: start accepted -> busy=1 next cycle. num_steps=0 -> FIN directly: done pulses once, no strobes.
- GATE: row r = 0..4*HID-1, L = 1+NX+NH cycles per row.
  - Cycle 0: b_valid, b_addr=r.
  - Cycles 1..NX: x_valid, k = 0..NX-1.
  - Cycles NX+1..NX+NH: h_valid, h_raddr = j = 0..NH-1.
  - row_last on the final cycle of each row.
  - Rows run back-to-back with no bubbles.
- gate_we/gate_waddr: row_last and r passed through a GATE_PIPE-deep shift pipe. The pipe keeps shifting in every state.
- DRAIN: exactly GATE_PIPE cycles, then NET, so the last gate write lands before any net read.
- NET: unit u = 0..HID-1, 6 cycles each (c = 0..5).
  - c=0: gate_raddr = HID+u, f_valid.
  - c=1: gate_raddr = u, gate_raddr2 = 2HID+u, i_valid.
  - c=3: accum_rst_net.
  - c=5: gate_raddr = 3HID+u, c_we, c_addr = u; h_new written into slot u%PACK of h_word (slot 0 = LSBs).
- h_we: pulses the cycle after c=5 when u%PACK = PACK-1, with h_waddr = u/PACK; h_word holds stable that cycle.
- Only one strobe-producing phase is active at a time. Outside its phase every strobe is 0; addresses hold.
- All counters wrap to 0 on phase exit.
- FIN: done=1 for one cycle, busy=0 same cycle, then IDLE. start in FIN is ignored.

Optional Feature:
- SEQ_STALL_EN defined: adds input stall (1 bit).
  - While stall=1: all state, counters and the gate pipe hold.
  - All strobes (b/x/h_valid, row_last, gate_we, accum_rst_gate, f/i_valid, accum_rst_net, c_we, h_we, done) forced 0.
  - Addresses hold.
  - A strobe due during stall issues on the first cycle after stall falls.
- SEQ_STALL_EN undefined: no stall port; sequencer never pauses.

Test Plan (HID=4, PACK=2, NX=1, GATE_PIPE=4, so NH=2, L=4):
- start, num_steps=1 -> 64 gate cycles, 16 row_last, 16 gate_we with gate_waddr 0..15. First gate_we 4 cycles after first row_last; NET starts after 4 drain cycles.
- Same run, net phase -> 4 c_we with c_addr 0..3. gate_raddr sequence for u=0 is 4,0,8-on-raddr2,12. h_we twice with h_waddr 0,1; h_word = {h_new(u1),h_new(u0)}.
- num_steps=3 -> x_addr reaches 0,1,2 in successive steps; done once, 3*(64+4+24)+1 cycles after start.
- num_steps=0 -> done one cycle later, zero strobes. start asserted while busy -> no effect on sequence.
- rst_n low mid-GATE at row 7 -> all outputs 0 asynchronously. A new start after release runs from row 0.
- SEQ_STALL_EN: stall held 10 cycles mid-row -> strobe sequence identical to the unstalled run, shifted by 10 cycles.
